nexys_starship_repair_arb: RTL and testbench
============================================

NEXYS_STARSHIP_REPAIR_ARB -- requirements
Module: nexys_starship_repair_arb

Interface
REQ-001 Parameters SHALL be: TIMEOUT_TICKS, default 8, timer_tick count allowed per repair session; MAX_TRIES, default 3, wrong submits allowed before failure.
REQ-002 Clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset: logic resets when Reset=0 and leaves reset on the first Clk edge after Reset=1.
REQ-004 play_flag  input  1  game in Play; requests are ignored when 0.
REQ-005 gameover_ctrl  input  1  game over; aborts any session when 1.
REQ-006 req  input  4  repair requests {right,left,btm,top} = bits [3:0] = {3,2,1,0}; level signals (the *_broken flags).
REQ-007 target_combo  input  16  required hex per requester; bits [4i+3:4i] belong to requester i.
REQ-008 hex_combo  input  4  value currently on Sw3..Sw0.
REQ-009 submit  input  1  one-cycle debounced submit pulse (BtnR).
REQ-010 timer_tick  input  1  one-cycle enable from the game timer.
REQ-011 grant  output  4  one-hot owner of the shared switch keypad; 0 when no session is active.
REQ-012 busy  output  1  session active; equals |grant.
REQ-013 active_combo  output  4  target_combo slice of the current grantee; 0 when idle.
REQ-014 repair_done  output  4  one-cycle pulse on bit i when requester i is repaired.
REQ-015 repair_fail  output  4  one-cycle pulse on bit i on timeout or tries exhausted.
REQ-016 tries_left  output  2  remaining wrong submits; for the SSD.

Function
REQ-017 The FSM SHALL have states IDLE, ENTRY, DONE and FAIL, with all outputs registered.
REQ-018 IDLE: when play_flag=1, gameover_ctrl=0 and req!=0, SHALL select a requester by round-robin and enter ENTRY; grant is valid on the next cycle.
REQ-019 Round-robin: SHALL search from rr_ptr upward modulo 4; after granting i, rr_ptr = (i+1) mod 4; reset value of rr_ptr is 0.
REQ-020 On entry to ENTRY, SHALL latch the requester index, load tick_cnt=0 and tries_left=MAX_TRIES, and set active_combo to that requester's target slice.
REQ-021 ENTRY with submit=1 and hex_combo==active_combo SHALL go to DONE.
REQ-022 ENTRY with submit=1 and a mismatch SHALL decrement tries_left; if tries_left was 1, SHALL go to FAIL instead.
REQ-023 ENTRY with timer_tick=1 SHALL increment tick_cnt; reaching TIMEOUT_TICKS SHALL go to FAIL.
REQ-024 A submit and a timeout in the same cycle SHALL resolve in favour of the submit (a matching submit repairs).
REQ-025 DONE SHALL pulse repair_done[idx] for exactly one cycle with grant=0, then go to IDLE.
REQ-026 FAIL SHALL pulse repair_fail[idx] for exactly one cycle with grant=0, then go to IDLE.
REQ-027 In ENTRY, if req[idx] drops, or play_flag=0, or gameover_ctrl=1, SHALL return to IDLE next cycle with no done/fail pulse; rr_ptr is unchanged.
REQ-028 submit in IDLE, DONE or FAIL SHALL be ignored.
REQ-029 grant SHALL never have more than one bit set.
REQ-030 target_combo SHALL be sampled continuously; a change mid-session SHALL take effect in active_combo the next cycle.
REQ-031 tick_cnt width SHALL be ceil(log2(TIMEOUT_TICKS+1)), and it SHALL saturate.

Reset
REQ-032 While Reset=0, outputs SHALL be: state=IDLE, grant=0, busy=0, active_combo=0, repair_done=0, repair_fail=0, tries_left=0, tick_cnt=0, rr_ptr=0.
REQ-033 Reset asserted mid-session SHALL clear all state immediately, with no done/fail pulse.

Verification
REQ-034 Scenario: play_flag=1, req=4'b0101, target[3:0]=4'hA -> grant=0001 one cycle later; hex_combo=A plus submit -> repair_done=0001 for one cycle; next grant=0100.
REQ-035 Scenario: grant=0010, three submits with hex_combo=3 and target=7 -> tries_left 3→2→1, then repair_fail=0010 pulse, grant=0.
REQ-036 Scenario: grant active, 8 timer_ticks with no submit -> repair_fail pulse on the cycle after the 8th tick; a matching submit together with the 8th tick -> repair_done instead.
REQ-037 Scenario: grant=1000, then req[3] drops -> grant=0 next cycle with no pulses; gameover_ctrl=1 mid-session gives the same result.
REQ-038 Scenario: req=4'b1111 held through 4 repairs -> grant order 0001, 0010, 0100, 1000.
REQ-039 Scenario: Reset=0 pulse during ENTRY -> all outputs 0 asynchronously; after release with req=0001, grant=0001.

Source files
------------

// File: rtl/nexys_starship_repair_arb.sv
// nexys_starship_repair_arb
// Shares the single switch keypad (Sw3..Sw0 + BtnR) among the four ship-section
// repair requesters. A requester is picked round-robin, gets a limited number of
// wrong submits and a limited number of game-timer ticks to dial its hex code,
// and the outcome is reported as a one-cycle done or fail pulse.
//
// Ports
//   Clk            system clock, rising edge
//   Reset          asynchronous active-low reset
//   play_flag      game in Play; new sessions only start while high
//   gameover_ctrl  game over; kills any running session
//   req[3:0]       repair request levels {right,left,btm,top}
//   target_combo   required hex per requester, nibble i for requester i
//   hex_combo      value on the switches
//   submit         one-cycle debounced submit pulse
//   timer_tick     one-cycle game timer enable
//   grant[3:0]     one-hot keypad owner, 0 when idle
//   busy           session active (|grant)
//   active_combo   target nibble of the current owner, 0 when idle
//   repair_done    one-cycle pulse for the repaired requester
//   repair_fail    one-cycle pulse on timeout or tries exhausted
//   tries_left     remaining wrong submits of the running session
module nexys_starship_repair_arb #(
  parameter int TIMEOUT_TICKS = 8,
  parameter int MAX_TRIES     = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic        gameover_ctrl,
  input  logic [3:0]  req,
  input  logic [15:0] target_combo,
  input  logic [3:0]  hex_combo,
  input  logic        submit,
  input  logic        timer_tick,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [3:0]  active_combo,
  output logic [3:0]  repair_done,
  output logic [3:0]  repair_fail,
  output logic [1:0]  tries_left
);

  localparam int            TW         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TICK_MAX   = TW'(TIMEOUT_TICKS);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  // Returns {found, index}: first set request at or above ptr, wrapping mod 4.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      res  = r[cand] ? {1'b1, cand} : res;
    end
    return res;
  endfunction

  function automatic logic [3:0] slice(input logic [15:0] t, input logic [1:0] i);
    return t[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    tries_q, tries_d;
  logic [3:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [3:0]    active_q, active_d;
  logic [3:0]    done_q, done_d;
  logic [3:0]    fail_q, fail_d;

  logic [2:0]    pick_s;
  logic          start_s;
  logic          abort_s;
  logic          match_s;
  logic          miss_s;
  logic          last_try_s;
  logic          timeout_s;

  assign pick_s     = rr_pick(req, rr_ptr_q);
  assign start_s    = play_flag & ~gameover_ctrl & pick_s[2];
  assign abort_s    = ~req[idx_q] | ~play_flag | gameover_ctrl;
  // Compare against the registered combo, i.e. what the player currently sees.
  assign match_s    = submit & (hex_combo == active_q);
  assign miss_s     = submit & (hex_combo != active_q);
  assign last_try_s = (tries_q == 2'd1);
  assign timeout_s  = timer_tick & (tick_cnt_q >= TICK_LAST);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort outranks everything; a matching submit outranks
  // the timeout landing in the same cycle.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        state_d = start_s ? S_ENTRY : S_IDLE;
      end
      S_ENTRY: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (match_s) begin
          state_d = S_DONE;
        end else if (miss_s && last_try_s) begin
          state_d = S_FAIL;
        end else if (timeout_s) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and session-datapath next values, derived from the transition taken.
  always_comb begin
    grant_d    = 4'b0000;
    active_d   = 4'b0000;
    done_d     = 4'b0000;
    fail_d     = 4'b0000;
    tries_d    = 2'b00;
    tick_cnt_d = {TW{1'b0}};
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    if ((state_q == S_IDLE) && (state_d == S_ENTRY)) begin
      idx_d    = pick_s[1:0];
      rr_ptr_d = pick_s[1:0] + 2'd1;
      grant_d  = onehot(pick_s[1:0]);
      active_d = slice(target_combo, pick_s[1:0]);
      tries_d  = TRIES_INIT;
    end else if (state_q == S_ENTRY) begin
      case (state_d)
        S_ENTRY: begin
          grant_d    = grant_q;
          active_d   = slice(target_combo, idx_q);
          tries_d    = miss_s ? (tries_q - 2'd1) : tries_q;
          tick_cnt_d = (timer_tick && (tick_cnt_q != TICK_MAX)) ?
                       (tick_cnt_q + TW'(1)) : tick_cnt_q;
        end
        S_DONE:  done_d = onehot(idx_q);
        S_FAIL:  fail_d = onehot(idx_q);
        default: done_d = 4'b0000;
      endcase
    end else begin
      grant_d = 4'b0000;
    end
    busy_d = |grant_d;
  end

  // Registered outputs and session bookkeeping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx_q      <= 2'd0;
      rr_ptr_q   <= 2'd0;
      tick_cnt_q <= {TW{1'b0}};
      tries_q    <= 2'd0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      active_q   <= 4'b0000;
      done_q     <= 4'b0000;
      fail_q     <= 4'b0000;
    end else begin
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      tick_cnt_q <= tick_cnt_d;
      tries_q    <= tries_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      active_q   <= active_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign active_combo = active_q;
  assign repair_done  = done_q;
  assign repair_fail  = fail_q;
  assign tries_left   = tries_q;

endmodule

// File: tb/tb_nexys_starship_repair_arb.sv
module tb_nexys_starship_repair_arb;

  localparam int TO = 8;
  localparam int MT = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        play_flag = 1'b0;
  logic        gameover_ctrl = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [15:0] target_combo = 16'h0000;
  logic [3:0]  hex_combo = 4'h0;
  logic        submit = 1'b0;
  logic        timer_tick = 1'b0;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  active_combo;
  logic [3:0]  repair_done;
  logic [3:0]  repair_fail;
  logic [1:0]  tries_left;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  nexys_starship_repair_arb #(.TIMEOUT_TICKS(TO), .MAX_TRIES(MT)) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .req(req), .target_combo(target_combo), .hex_combo(hex_combo), .submit(submit),
    .timer_tick(timer_tick), .grant(grant), .busy(busy), .active_combo(active_combo),
    .repair_done(repair_done), .repair_fail(repair_fail), .tries_left(tries_left)
  );

  // Reference model: session described by owner, remaining tries and remaining ticks.
  int m_mode;   // 0 idle, 1 session, 2 reporting outcome
  int m_owner;
  int m_rr;
  int m_tries;
  int m_ticks;
  logic [3:0] e_grant, e_active, e_done, e_fail;
  logic [1:0] e_tries;

  function automatic logic [3:0] nib(input logic [15:0] t, input int i);
    return 4'((t >> (4 * i)) & 16'h000F);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_rr = 0; m_tries = 0; m_ticks = 0;
    e_grant = 4'h0; e_active = 4'h0; e_done = 4'h0; e_fail = 4'h0; e_tries = 2'd0;
  endtask

  task automatic model_step();
    logic [3:0] prev_active;
    if (!Reset) begin
      model_reset();
      return;
    end
    prev_active = e_active;
    e_grant = 4'h0; e_active = 4'h0; e_done = 4'h0; e_fail = 4'h0; e_tries = 2'd0;
    case (m_mode)
      1: begin
        if (!req[m_owner] || !play_flag || gameover_ctrl) begin
          m_mode = 0;
        end else if (submit && hex_combo == prev_active) begin
          e_done = 4'(1 << m_owner);
          m_mode = 2;
        end else begin
          if (submit) m_tries = m_tries - 1;
          if (timer_tick && m_ticks > 0) m_ticks = m_ticks - 1;
          if (m_tries == 0 || m_ticks == 0) begin
            e_fail = 4'(1 << m_owner);
            m_mode = 2;
          end else begin
            e_grant = 4'(1 << m_owner);
            e_active = nib(target_combo, m_owner);
            e_tries = 2'(m_tries);
          end
        end
      end
      2: m_mode = 0;
      default: begin
        if (play_flag && !gameover_ctrl && req != 4'h0) begin
          for (int k = 3; k >= 0; k--)
            if (req[(m_rr + k) % 4]) m_owner = (m_rr + k) % 4;
          m_rr = (m_owner + 1) % 4;
          m_tries = MT;
          m_ticks = TO;
          m_mode = 1;
          e_grant = 4'(1 << m_owner);
          e_active = nib(target_combo, m_owner);
          e_tries = 2'(MT);
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"}, {12'h000, grant}, {12'h000, e_grant});
    chk({tag, ".busy"}, {15'h0000, busy}, {15'h0000, |e_grant});
    chk({tag, ".active"}, {12'h000, active_combo}, {12'h000, e_active});
    chk({tag, ".done"}, {12'h000, repair_done}, {12'h000, e_done});
    chk({tag, ".fail"}, {12'h000, repair_fail}, {12'h000, e_fail});
    chk({tag, ".tries"}, {14'h0000, tries_left}, {14'h0000, e_tries});
  endtask

  task automatic step(input bit cmp, input string tag);
    @(posedge Clk);
    model_step();
    #1;
    if (cmp) check_all(tag);
  endtask

  task automatic do_reset();
    Reset = 1'b0; play_flag = 1'b0; gameover_ctrl = 1'b0; req = 4'h0;
    submit = 1'b0; timer_tick = 1'b0; hex_combo = 4'h0; target_combo = 16'h0000;
    step(1'b1, "rst");
    Reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [15:0] tgt;
    logic [3:0]  hx;
    logic        sb;
    logic [3:0]  g;
    logic [3:0]  act;
    logic [3:0]  d;
    logic [3:0]  f;
    logic [1:0]  tr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0101, 16'h050A, 4'h0, 1'b0, 4'b0001, 4'hA, 4'b0000, 4'b0000, 2'd3};
    tbl[1] = '{4'b0101, 16'h050A, 4'hA, 1'b1, 4'b0000, 4'h0, 4'b0001, 4'b0000, 2'd0};
    tbl[2] = '{4'b0101, 16'h050A, 4'h0, 1'b0, 4'b0000, 4'h0, 4'b0000, 4'b0000, 2'd0};
    tbl[3] = '{4'b0101, 16'h050A, 4'h0, 1'b0, 4'b0100, 4'h5, 4'b0000, 4'b0000, 2'd3};
    tbl[4] = '{4'b0010, 16'h0070, 4'h0, 1'b0, 4'b0000, 4'h0, 4'b0000, 4'b0000, 2'd0};
    tbl[5] = '{4'b0010, 16'h0070, 4'h0, 1'b0, 4'b0010, 4'h7, 4'b0000, 4'b0000, 2'd3};
    tbl[6] = '{4'b0010, 16'h0070, 4'h3, 1'b1, 4'b0010, 4'h7, 4'b0000, 4'b0000, 2'd2};
    tbl[7] = '{4'b0010, 16'h0070, 4'h3, 1'b1, 4'b0010, 4'h7, 4'b0000, 4'b0000, 2'd1};
    tbl[8] = '{4'b0010, 16'h0070, 4'h3, 1'b1, 4'b0000, 4'h0, 4'b0000, 4'b0010, 2'd0};
    tbl[9] = '{4'b0010, 16'h0070, 4'h3, 1'b0, 4'b0000, 4'h0, 4'b0000, 4'b0000, 2'd0};

    model_reset();
    // Reset state, observed while Reset is still low.
    step(1'b0, "init");
    chk("reset.grant", {12'h000, grant}, 16'h0000);
    chk("reset.busy", {15'h0000, busy}, 16'h0000);
    chk("reset.active", {12'h000, active_combo}, 16'h0000);
    chk("reset.done", {12'h000, repair_done}, 16'h0000);
    chk("reset.fail", {12'h000, repair_fail}, 16'h0000);
    chk("reset.tries", {14'h0000, tries_left}, 16'h0000);

    // Table: repair, round-robin advance, abort, tries exhaustion.
    do_reset();
    play_flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].rq; target_combo = tbl[i].tgt; hex_combo = tbl[i].hx; submit = tbl[i].sb;
      step(1'b0, "tbl");
      chk($sformatf("tbl%0d.grant", i), {12'h000, grant}, {12'h000, tbl[i].g});
      chk($sformatf("tbl%0d.busy", i), {15'h0000, busy}, {15'h0000, |tbl[i].g});
      chk($sformatf("tbl%0d.active", i), {12'h000, active_combo}, {12'h000, tbl[i].act});
      chk($sformatf("tbl%0d.done", i), {12'h000, repair_done}, {12'h000, tbl[i].d});
      chk($sformatf("tbl%0d.fail", i), {12'h000, repair_fail}, {12'h000, tbl[i].f});
      chk($sformatf("tbl%0d.tries", i), {14'h0000, tries_left}, {14'h0000, tbl[i].tr});
    end
    submit = 1'b0;

    // Timeout after the 8th tick.
    do_reset();
    play_flag = 1'b1; req = 4'b0001; target_combo = 16'h000A;
    step(1'b1, "to.grant");
    timer_tick = 1'b1;
    for (int i = 0; i < TO - 1; i++) step(1'b1, "to.tick");
    step(1'b1, "to.last");
    chk("timeout.fail", {12'h000, repair_fail}, 16'h0001);
    timer_tick = 1'b0;
    step(1'b1, "to.after");
    chk("timeout.pulse_one_cycle", {12'h000, repair_fail}, 16'h0000);

    // Matching submit together with the 8th tick repairs.
    do_reset();
    play_flag = 1'b1; req = 4'b0001; target_combo = 16'h000A;
    step(1'b1, "tos.grant");
    timer_tick = 1'b1;
    for (int i = 0; i < TO - 1; i++) step(1'b1, "tos.tick");
    hex_combo = 4'hA; submit = 1'b1;
    step(1'b1, "tos.last");
    chk("tick_submit.done", {12'h000, repair_done}, 16'h0001);
    chk("tick_submit.nofail", {12'h000, repair_fail}, 16'h0000);
    timer_tick = 1'b0; submit = 1'b0;
    step(1'b1, "tos.after");

    // Request drop and gameover abort.
    do_reset();
    play_flag = 1'b1; req = 4'b1000; target_combo = 16'h9000;
    step(1'b1, "ab.grant");
    chk("abort.grant3", {12'h000, grant}, 16'h0008);
    req = 4'b0000;
    step(1'b1, "ab.drop");
    chk("abort.drop_grant", {12'h000, grant}, 16'h0000);
    chk("abort.drop_pulses", {8'h00, repair_done, repair_fail}, 16'h0000);
    req = 4'b1000;
    step(1'b1, "ab.regrant");
    chk("abort.regrant3", {12'h000, grant}, 16'h0008);
    gameover_ctrl = 1'b1;
    step(1'b1, "ab.go");
    chk("abort.go_grant", {12'h000, grant}, 16'h0000);
    chk("abort.go_pulses", {8'h00, repair_done, repair_fail}, 16'h0000);
    gameover_ctrl = 1'b0;

    // Round-robin order with all four requesting.
    do_reset();
    play_flag = 1'b1; req = 4'b1111; target_combo = 16'h4321;
    for (int n = 0; n < 4; n++) begin
      step(1'b1, "rr.grant");
      chk($sformatf("rr.order%0d", n), {12'h000, grant}, 16'(1 << n));
      hex_combo = nib(16'h4321, n); submit = 1'b1;
      step(1'b1, "rr.done");
      chk($sformatf("rr.done%0d", n), {12'h000, repair_done}, 16'(1 << n));
      submit = 1'b0;
      step(1'b1, "rr.idle");
    end

    // Target change mid-session is visible next cycle and used for matching.
    do_reset();
    play_flag = 1'b1; req = 4'b0001; target_combo = 16'h000A;
    step(1'b1, "tc.grant");
    target_combo = 16'h000B;
    step(1'b1, "tc.change");
    chk("tgt_change.active", {12'h000, active_combo}, 16'h000B);
    hex_combo = 4'hA; submit = 1'b1;
    step(1'b1, "tc.miss");
    chk("tgt_change.tries", {14'h0000, tries_left}, 16'h0002);
    submit = 1'b0;

    // Asynchronous reset during a session.
    #2 Reset = 1'b0;
    #1;
    chk("areset.grant", {12'h000, grant}, 16'h0000);
    chk("areset.busy", {15'h0000, busy}, 16'h0000);
    chk("areset.active", {12'h000, active_combo}, 16'h0000);
    chk("areset.pulses", {8'h00, repair_done, repair_fail}, 16'h0000);
    chk("areset.tries", {14'h0000, tries_left}, 16'h0000);
    model_reset();
    step(1'b1, "ar.hold");
    Reset = 1'b1; req = 4'b0001;
    step(1'b1, "ar.release");
    chk("areset.regrant", {12'h000, grant}, 16'h0001);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      Reset = ($urandom_range(0, 399) != 0);
      play_flag = ($urandom_range(0, 19) != 0);
      gameover_ctrl = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      if ($urandom_range(0, 29) == 0) target_combo = 16'($urandom);
      hex_combo = ($urandom_range(0, 1) == 1) ? e_active : 4'($urandom);
      submit = ($urandom_range(0, 3) == 0);
      timer_tick = ($urandom_range(0, 2) == 0);
      step(1'b1, "rand");
      chk("rand.onehot", {15'h0000, $countones(grant) > 1}, 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
